pacman_mover: RTL and testbench
===============================

// Module: pacman_mover
// PURPOSE
//  Parametrised tile-grid actor mover; next generation of the in-game Pac-Man motion logic.
//  Latches button requests as a queued turn, checks walls through a 1-cycle-latency map RAM read port,
//  and steps the actor STEP px per frame_stb. Adds buffered turns, instant reversal, and a horizontal tunnel wrap.
//  Sits between the button inputs and the sprite renderer; one instance per actor.
// PARAMETERS
//  MAP_COLS   32   tiles per map row (also the row stride of map_addr)
//  MAP_ROWS   36   tile rows
//  TILE_SIZE  8    pixels per tile edge; power of two
//  STEP       1    pixels moved per frame; must divide TILE_SIZE
//  START_X    96   reset x (px); must be tile aligned
//  START_Y    64   reset y (px); must be tile aligned
//  TUNNEL_EN  1    1: horizontal wrap at map edges; 0: off-map tiles count as walls
// PORTS
//  clk            in   1   system clock
//  rst            in   1   synchronous, active-high reset
//  frame_stb      in   1   1-cycle pulse per frame; starts one update
//  BTNU/BTND/BTNL/BTNR in 1 each  direction buttons, level, already synchronised
//  map_rd_en      out  1   map read strobe
//  map_addr       out  $clog2(MAP_COLS*MAP_ROWS)  row*MAP_COLS+col
//  map_data       in   2   tile value; valid the cycle after map_rd_en
//  x_pos          out  $clog2(MAP_COLS*TILE_SIZE)  sprite top-left x (px)
//  y_pos          out  $clog2(MAP_ROWS*TILE_SIZE)  sprite top-left y (px)
//  dir            out  2   0=UP 1=DOWN 2=LEFT 3=RIGHT
//  moving         out  1   actor advancing in dir
//  busy           out  1   FSM not IDLE
//  frame_overrun  out  1   1-cycle pulse: frame_stb arrived while busy; that frame is dropped
// BEHAVIOUR
//  Reset: x_pos=START_X, y_pos=START_Y, dir=LEFT, moving=0, queue empty, FSM=IDLE.
//   All strobes are 0. Reset mid-update aborts the update immediately.
//  Queue: sampled every cycle. Pressed button with priority U>D>L>R overwrites q_dir and sets q_vld.
//   No press leaves the queue unchanged. The queue clears when its direction is adopted.
//  Aligned: x_pos%TILE_SIZE==0 and y_pos%TILE_SIZE==0.
//   Tile col/row = pos/TILE_SIZE. Neighbour = tile +/-1 in the given direction.
//  Wall: map_data[0]==1. Value 2'b10 (pellet) is passable.
//   Off-map row always counts as a wall; no read is issued.
//   Off-map col: wraps mod MAP_COLS if TUNNEL_EN, otherwise counts as a wall with no read.
//  FSM, one state per cycle:
//   IDLE: on frame_stb go to CHK_Q.
//   CHK_Q:
//    q_vld, moving, q_dir opposite dir -> dir<=q_dir, clear q, go to MOVE (reversal needs no read).
//    q_vld, aligned, q_dir!=dir or !moving -> map_rd_en=1 for q_dir neighbour, go to WAIT_Q.
//    Otherwise go to CHK_C.
//   WAIT_Q:
//    Free -> dir<=q_dir, moving<=1, clear q, go to MOVE.
//    Wall -> keep q, go to CHK_C.
//   CHK_C:
//    !moving -> IDLE.
//    Moving and not aligned -> MOVE.
//    Moving and aligned -> read dir neighbour, go to WAIT_C.
//   WAIT_C: wall -> moving<=0, go to IDLE; free -> MOVE.
//   MOVE: pos += STEP in dir, then IDLE.
//  Latency: position is updated at most 6 clk after frame_stb; busy=0 afterwards.
//  Wrap (TUNNEL_EN): x=0 moving LEFT -> x=MAP_COLS*TILE_SIZE-STEP.
//   x=MAP_COLS*TILE_SIZE-STEP moving RIGHT -> x=0.
//   Mid-tile steps need no map check; the next tile was validated at alignment.
//  frame_stb while busy: ignored, frame_overrun pulses, the current update completes.
//  Width: intermediate address math done at map_addr width + 1; no truncation before the mod.
// TESTING
//  T1 reset: rst 1 clk -> x=96 y=64 dir=LEFT moving=0 busy=0 map_rd_en=0.
//  T2 free run: map all 0, hold BTNR, 8 frames -> x 96->104; first read addr=8*32+13=269; dir=RIGHT.
//  T3 wall: tile(13,8)=1, hold BTNR -> read addr 269, x stays 96, moving=0.
//  T4 queued turn: moving RIGHT from x=96 in a corridor; tap BTNU at x=98.
//   -> at x=104 read addr 7*32+13=237, tile free -> dir=UP; next frame y=63.
//  T5 reversal: moving RIGHT at x=100, press BTNL -> next frame x=99, dir=LEFT, no map_rd_en.
//  T6 tunnel and overrun: TUNNEL_EN=1, x=0 y=64 moving LEFT, tile(31,8) free.
//   -> read addr 287, x=255. A second frame_stb 2 clk later -> frame_overrun=1 for 1 clk.

Source files
------------

// File: rtl/pacman_mover.sv
// Tile-grid actor mover: buffered turns, instant reversal, wall checks through a 1-cycle map RAM, tunnel wrap.
// An update takes at most 6 clk from frame_stb; a frame_stb arriving mid-update is dropped and flagged.
module pacman_mover #(
    parameter int MAP_COLS  = 32,
    parameter int MAP_ROWS  = 36,
    parameter int TILE_SIZE = 8,
    parameter int STEP      = 1,
    parameter int START_X   = 96,
    parameter int START_Y   = 64,
    parameter int TUNNEL_EN = 1,
    localparam int AW = $clog2(MAP_COLS*MAP_ROWS),
    localparam int XW = $clog2(MAP_COLS*TILE_SIZE),
    localparam int YW = $clog2(MAP_ROWS*TILE_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_stb,
    input  logic          BTNU,
    input  logic          BTND,
    input  logic          BTNL,
    input  logic          BTNR,
    output logic          map_rd_en,
    output logic [AW-1:0] map_addr,
    input  logic [1:0]    map_data,
    output logic [XW-1:0] x_pos,
    output logic [YW-1:0] y_pos,
    output logic [1:0]    dir,
    output logic          moving,
    output logic          busy,
    output logic          frame_overrun
);
    localparam int W      = AW + 1;
    localparam int TS_LOG = $clog2(TILE_SIZE);

    localparam logic [W-1:0]  LP_ONE   = W'(1);
    localparam logic [W-1:0]  LP_COLS  = W'(MAP_COLS);
    localparam logic [W-1:0]  LP_COLS2 = W'(2*MAP_COLS);
    localparam logic [W-1:0]  LP_ROWS  = W'(MAP_ROWS);
    localparam logic [W-1:0]  LP_ROWS2 = W'(2*MAP_ROWS);
    localparam logic [XW-1:0] X_LAST   = XW'(MAP_COLS*TILE_SIZE - STEP);
    localparam logic [XW-1:0] X_STEP   = XW'(STEP);
    localparam logic [YW-1:0] Y_STEP   = YW'(STEP);

    localparam logic [1:0] D_UP    = 2'd0;
    localparam logic [1:0] D_DOWN  = 2'd1;
    localparam logic [1:0] D_LEFT  = 2'd2;
    localparam logic [1:0] D_RIGHT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_CHK_Q, S_WAIT_Q, S_CHK_C, S_WAIT_C, S_MOVE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [1:0]    r_dir, r_q_dir, w_btn_dir, w_chk_dir;
    logic          r_moving, r_q_vld, r_nord, r_overrun;
    logic          w_btn_any, w_aligned, w_rd, w_take_q, w_stop, w_step;
    logic [W-1:0]  w_col, w_row, w_col_ext, w_row_ext, w_ncol, w_nrow, w_addr_ext;
    logic          w_col_oor, w_row_oor, w_nord;
    logic          w_unused;

    assign w_btn_any = BTNU | BTND | BTNL | BTNR;

    always_comb begin
        w_btn_dir = D_RIGHT;
        if (BTNU)      w_btn_dir = D_UP;
        else if (BTND) w_btn_dir = D_DOWN;
        else if (BTNL) w_btn_dir = D_LEFT;
    end

    assign w_aligned = (r_x[TS_LOG-1:0] == '0) && (r_y[TS_LOG-1:0] == '0);
    assign w_chk_dir = (r_state == S_CHK_Q) ? r_q_dir : r_dir;
    assign w_col     = W'(r_x >> TS_LOG);
    assign w_row     = W'(r_y >> TS_LOG);

    // Neighbour coordinates are biased by one map size so -1 stays positive until the range check.
    always_comb begin
        w_col_ext = w_col + LP_COLS;
        w_row_ext = w_row + LP_ROWS;
        case (w_chk_dir)
            D_UP:    w_row_ext = w_row + LP_ROWS - LP_ONE;
            D_DOWN:  w_row_ext = w_row + LP_ROWS + LP_ONE;
            D_LEFT:  w_col_ext = w_col + LP_COLS - LP_ONE;
            default: w_col_ext = w_col + LP_COLS + LP_ONE;
        endcase
    end

    assign w_col_oor  = (w_col_ext < LP_COLS) || (w_col_ext >= LP_COLS2);
    assign w_row_oor  = (w_row_ext < LP_ROWS) || (w_row_ext >= LP_ROWS2);
    assign w_ncol     = (w_col_ext < LP_COLS)   ? (LP_COLS - LP_ONE) :
                        (w_col_ext >= LP_COLS2) ? '0 : (w_col_ext - LP_COLS);
    assign w_nrow     = w_row_ext - LP_ROWS;
    assign w_nord     = w_row_oor || (w_col_oor && (TUNNEL_EN == 0));
    assign w_addr_ext = w_nrow * LP_COLS + w_ncol;
    assign w_unused   = ^{map_data[1], w_addr_ext[AW]};

    always_comb begin
        w_state_nxt = r_state;
        w_rd        = 1'b0;
        w_take_q    = 1'b0;
        w_stop      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: if (frame_stb) w_state_nxt = S_CHK_Q;
            S_CHK_Q: begin
                if (r_q_vld && r_moving && (r_q_dir == (r_dir ^ 2'b01))) begin
                    w_take_q    = 1'b1;
                    w_state_nxt = S_MOVE;
                end else if (r_q_vld && w_aligned && ((r_q_dir != r_dir) || !r_moving)) begin
                    w_rd        = !w_nord;
                    w_state_nxt = S_WAIT_Q;
                end else begin
                    w_state_nxt = S_CHK_C;
                end
            end
            S_WAIT_Q: begin
                if (!r_nord && !map_data[0]) begin
                    w_take_q    = 1'b1;
                    w_state_nxt = S_MOVE;
                end else begin
                    w_state_nxt = S_CHK_C;
                end
            end
            S_CHK_C: begin
                if (!r_moving) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_aligned) begin
                    w_state_nxt = S_MOVE;
                end else begin
                    w_rd        = !w_nord;
                    w_state_nxt = S_WAIT_C;
                end
            end
            S_WAIT_C: begin
                if (r_nord || map_data[0]) begin
                    w_stop      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_MOVE;
                end
            end
            S_MOVE: begin
                w_step      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= XW'(START_X);
            r_y       <= YW'(START_Y);
            r_dir     <= D_LEFT;
            r_moving  <= 1'b0;
            r_q_vld   <= 1'b0;
            r_q_dir   <= D_LEFT;
            r_nord    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // Sampled every cycle so the WAIT states see the no-read verdict of the preceding CHK state.
            r_nord    <= w_nord;
            r_overrun <= frame_stb && (r_state != S_IDLE);
            if (w_take_q) begin
                r_dir    <= r_q_dir;
                r_moving <= 1'b1;
                r_q_vld  <= 1'b0;
            end
            if (w_btn_any) begin
                r_q_vld <= 1'b1;
                r_q_dir <= w_btn_dir;
            end
            if (w_stop) r_moving <= 1'b0;
            if (w_step) begin
                case (r_dir)
                    D_UP:    r_y <= r_y - Y_STEP;
                    D_DOWN:  r_y <= r_y + Y_STEP;
                    D_LEFT:  r_x <= ((TUNNEL_EN != 0) && (r_x == '0)) ? X_LAST : (r_x - X_STEP);
                    default: r_x <= ((TUNNEL_EN != 0) && (r_x == X_LAST)) ? '0 : (r_x + X_STEP);
                endcase
            end
        end
    end

    assign map_rd_en     = w_rd;
    assign map_addr      = w_addr_ext[AW-1:0];
    assign x_pos         = r_x;
    assign y_pos         = r_y;
    assign dir           = r_dir;
    assign moving        = r_moving;
    assign busy          = (r_state != S_IDLE);
    assign frame_overrun = r_overrun;
endmodule

// File: tb/tb_pacman_mover.sv
// Bench for pacman_mover: directed frame table, hand sequences for corner cases, random frames vs a tile-level model.
module tb_pacman_mover;
    localparam int COLS = 32, ROWS = 36, TS = 8, STEP = 1, XMAX = COLS*TS;
    localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

    logic        clk = 1'b0, rst = 1'b1, frame_stb = 1'b0;
    logic [3:0]  btn = 4'h0;
    logic        BTNU, BTND, BTNL, BTNR;
    logic        map_rd_en;
    logic [10:0] map_addr;
    logic [1:0]  map_data = 2'b00;
    logic [7:0]  x_pos;
    logic [8:0]  y_pos;
    logic [1:0]  dir;
    logic        moving, busy, frame_overrun;

    assign {BTNU, BTND, BTNL, BTNR} = btn;
    always #5 clk = ~clk;

    pacman_mover #(
        .MAP_COLS(COLS), .MAP_ROWS(ROWS), .TILE_SIZE(TS), .STEP(STEP),
        .START_X(96), .START_Y(64), .TUNNEL_EN(1)
    ) dut (
        .clk(clk), .rst(rst), .frame_stb(frame_stb),
        .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
        .map_rd_en(map_rd_en), .map_addr(map_addr), .map_data(map_data),
        .x_pos(x_pos), .y_pos(y_pos), .dir(dir), .moving(moving),
        .busy(busy), .frame_overrun(frame_overrun)
    );

    bit [1:0] tiles [COLS*ROWS];
    int rd_cnt = 0, rd_last = -1;
    always @(posedge clk) begin
        if (map_rd_en) begin
            map_data <= tiles[map_addr];
            rd_cnt   <= rd_cnt + 1;
            rd_last  <= int'(map_addr);
        end
    end

    int errors = 0, checks = 0;
    int mx, my, mdir, mqd;
    bit mmov, mqv;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int prio(input logic [3:0] b);
        if (b[3]) return UP;
        if (b[2]) return DOWN;
        if (b[1]) return LEFT;
        return RIGHT;
    endfunction

    function automatic int opp(input int d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

    task automatic neighbour(input int d, output int a, output bit off);
        int c, r;
        c = mx / TS;
        r = my / TS;
        case (d)
            UP:      r = r - 1;
            DOWN:    r = r + 1;
            LEFT:    c = c - 1;
            default: c = c + 1;
        endcase
        off = (r < 0) || (r >= ROWS);
        c = (c + COLS) % COLS;
        a = r*COLS + c;
    endtask

    task automatic model_reset();
        mx = 96; my = 64; mdir = LEFT; mmov = 0; mqv = 0; mqd = 0;
    endtask

    // One frame of the movement rules at tile level; returns the reads it expects.
    task automatic model_frame(output int nrd, output int last);
        int a; bit off, aligned, go_c, domove;
        nrd = 0; last = -1; go_c = 1; domove = 0;
        if (btn != 0) begin mqv = 1; mqd = prio(btn); end
        aligned = (mx % TS == 0) && (my % TS == 0);
        if (mqv && mmov && mqd == opp(mdir)) begin
            mdir = mqd; mqv = 0; domove = 1; go_c = 0;
        end else if (mqv && aligned && (mqd != mdir || !mmov)) begin
            neighbour(mqd, a, off);
            if (!off) begin nrd++; last = a; end
            if (!off && tiles[a][0] == 1'b0) begin
                mdir = mqd; mmov = 1; mqv = 0; domove = 1; go_c = 0;
            end
        end
        if (go_c && mmov) begin
            if (!aligned) domove = 1;
            else begin
                neighbour(mdir, a, off);
                if (!off) begin nrd++; last = a; end
                if (off || tiles[a][0] == 1'b1) mmov = 0;
                else domove = 1;
            end
        end
        if (domove) begin
            case (mdir)
                UP:      my = my - STEP;
                DOWN:    my = my + STEP;
                LEFT:    mx = (mx + XMAX - STEP) % XMAX;
                default: mx = (mx + STEP) % XMAX;
            endcase
        end
        if (btn != 0) begin mqv = 1; mqd = prio(btn); end
    endtask

    task automatic run_frame(output int lat);
        @(negedge clk) frame_stb = 1'b1;
        @(negedge clk) frame_stb = 1'b0;
        lat = 1;
        while (busy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_frame(input string nm);
        int enr, elast, c0, lat;
        model_frame(enr, elast);
        c0 = rd_cnt;
        run_frame(lat);
        chk({nm, " x"}, int'(x_pos), mx);
        chk({nm, " y"}, int'(y_pos), my);
        chk({nm, " dir"}, int'(dir), mdir);
        chk({nm, " moving"}, int'(moving), int'(mmov));
        chk({nm, " reads"}, rd_cnt - c0, enr);
        if (enr > 0) chk({nm, " addr"}, rd_last, elast);
        chk({nm, " lat<=6"}, int'(lat <= 6 && !busy), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; btn = 4'h0; frame_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic clear_map();
        for (int i = 0; i < COLS*ROWS; i++) tiles[i] = 2'b00;
    endtask

    typedef struct {
        logic [3:0] b;
        int x, y, d;
        bit mv;
        int nrd, addr;
    } vec_t;
    vec_t tbl [21];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0, lat, enr, elast, r;
        // Free map from reset at (96,64): buttons {U,D,L,R}, expected position/dir/moving/reads.
        tbl[0]  = '{4'h1,  97, 64, RIGHT, 1, 1, 269};
        tbl[1]  = '{4'h1,  98, 64, RIGHT, 1, 0, 0};
        tbl[2]  = '{4'h1,  99, 64, RIGHT, 1, 0, 0};
        tbl[3]  = '{4'h1, 100, 64, RIGHT, 1, 0, 0};
        tbl[4]  = '{4'h1, 101, 64, RIGHT, 1, 0, 0};
        tbl[5]  = '{4'h1, 102, 64, RIGHT, 1, 0, 0};
        tbl[6]  = '{4'h1, 103, 64, RIGHT, 1, 0, 0};
        tbl[7]  = '{4'h1, 104, 64, RIGHT, 1, 0, 0};
        tbl[8]  = '{4'h1, 105, 64, RIGHT, 1, 1, 270};
        tbl[9]  = '{4'h2, 104, 64, LEFT,  1, 0, 0};
        tbl[10] = '{4'h0, 103, 64, LEFT,  1, 1, 268};
        tbl[11] = '{4'h8, 102, 64, LEFT,  1, 0, 0};
        tbl[12] = '{4'h0, 101, 64, LEFT,  1, 0, 0};
        tbl[13] = '{4'h0, 100, 64, LEFT,  1, 0, 0};
        tbl[14] = '{4'h0,  99, 64, LEFT,  1, 0, 0};
        tbl[15] = '{4'h0,  98, 64, LEFT,  1, 0, 0};
        tbl[16] = '{4'h0,  97, 64, LEFT,  1, 0, 0};
        tbl[17] = '{4'h0,  96, 64, LEFT,  1, 0, 0};
        tbl[18] = '{4'h0,  96, 63, UP,    1, 1, 236};
        tbl[19] = '{4'h4,  96, 64, DOWN,  1, 0, 0};
        tbl[20] = '{4'h0,  96, 65, DOWN,  1, 1, 300};

        clear_map();
        do_reset();
        chk("reset x", int'(x_pos), 96);
        chk("reset y", int'(y_pos), 64);
        chk("reset dir", int'(dir), LEFT);
        chk("reset moving", int'(moving), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset rd_en", int'(map_rd_en), 0);
        chk("reset overrun", int'(frame_overrun), 0);

        for (int i = 0; i < 21; i++) begin
            btn = tbl[i].b;
            c0 = rd_cnt;
            run_frame(lat);
            chk($sformatf("tbl%0d x", i), int'(x_pos), tbl[i].x);
            chk($sformatf("tbl%0d y", i), int'(y_pos), tbl[i].y);
            chk($sformatf("tbl%0d dir", i), int'(dir), tbl[i].d);
            chk($sformatf("tbl%0d moving", i), int'(moving), int'(tbl[i].mv));
            chk($sformatf("tbl%0d reads", i), rd_cnt - c0, tbl[i].nrd);
            if (tbl[i].nrd > 0) chk($sformatf("tbl%0d addr", i), rd_last, tbl[i].addr);
        end

        // Wall straight ahead of a stationary actor.
        do_reset();
        tiles[269] = 2'b01;
        btn = 4'h1;
        check_frame("wall");
        chk("wall x", int'(x_pos), 96);
        chk("wall moving", int'(moving), 0);
        chk("wall addr", rd_last, 269);
        tiles[269] = 2'b00;

        // Queued turn: tap UP mid-tile, taken at the next alignment.
        do_reset();
        btn = 4'h1;
        check_frame("qturn r0");
        check_frame("qturn r1");
        btn = 4'h0;
        @(negedge clk) btn = 4'h8;
        @(negedge clk) btn = 4'h0;
        mqv = 1; mqd = UP;
        for (int i = 0; i < 6; i++) check_frame($sformatf("qturn mid%0d", i));
        chk("qturn at104", int'(x_pos), 104);
        check_frame("qturn take");
        chk("qturn addr", rd_last, 237);
        chk("qturn dir", int'(dir), UP);
        chk("qturn y", int'(y_pos), 63);

        // Reversal mid-tile needs no read.
        do_reset();
        btn = 4'h1;
        for (int i = 0; i < 4; i++) check_frame($sformatf("rev pre%0d", i));
        btn = 4'h2;
        c0 = rd_cnt;
        check_frame("rev");
        chk("rev x", int'(x_pos), 99);
        chk("rev dir", int'(dir), LEFT);
        chk("rev noread", rd_cnt - c0, 0);

        // Reset in the middle of an update.
        do_reset();
        btn = 4'h1;
        @(negedge clk) frame_stb = 1'b1;
        @(negedge clk) frame_stb = 1'b0;
        @(negedge clk) begin rst = 1'b1; btn = 4'h0; end
        @(negedge clk);
        chk("abort busy", int'(busy), 0);
        chk("abort x", int'(x_pos), 96);
        chk("abort moving", int'(moving), 0);
        chk("abort rd_en", int'(map_rd_en), 0);
        rst = 1'b0;
        model_reset();

        // Tunnel wrap at x=0 plus a frame arriving while busy.
        do_reset();
        btn = 4'h2;
        check_frame("tun start");
        btn = 4'h0;
        for (int i = 0; i < 95; i++) check_frame($sformatf("tun walk%0d", i));
        chk("tun at0", int'(x_pos), 0);
        model_frame(enr, elast);
        c0 = rd_cnt;
        @(negedge clk) frame_stb = 1'b1;
        @(negedge clk) frame_stb = 1'b0;
        @(negedge clk) frame_stb = 1'b1;
        @(negedge clk) frame_stb = 1'b0;
        chk("ovr pulse", int'(frame_overrun), 1);
        @(negedge clk);
        chk("ovr clear", int'(frame_overrun), 0);
        for (int k = 0; k < 10 && busy; k++) @(negedge clk);
        chk("tun idle", int'(busy), 0);
        chk("tun x", int'(x_pos), 255);
        chk("tun model x", int'(x_pos), mx);
        chk("tun reads", rd_cnt - c0, enr);
        chk("tun addr", rd_last, 287);
        @(negedge clk);
        chk("tun dropped", int'(busy), 0);

        // Random maps and buttons against the model.
        do_reset();
        for (int i = 0; i < COLS*ROWS; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      tiles[i] = 2'b01;
            else if (r == 2) tiles[i] = 2'b11;
            else if (r < 5) tiles[i] = 2'b10;
            else            tiles[i] = 2'b00;
        end
        tiles[8*COLS + 0]  = 2'b00;
        tiles[8*COLS + 31] = 2'b00;
        for (int f = 0; f < 300; f++) begin
            if ($urandom_range(0, 1) == 0) btn = 4'h0;
            else btn = 4'($urandom_range(1, 15));
            check_frame($sformatf("rnd%0d", f));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
